load_store_unit: RTL and testbench

//  Memory-access stage between the execute stage and the word-addressed data memory.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-addressed load/store requests to a word-addressed memory.
// Sub-word stores use read-modify-write because the memory has only a whole-word write enable.

module lsu_lane (
  input  logic       sel,
  input  logic [7:0] rbyte,
  input  logic [7:0] wbyte,
  output logic [7:0] mbyte
);
  assign mbyte = sel ? wbyte : rbyte;
endmodule

module load_store_unit #(
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int CW        = 3;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  boff;
    logic [31:0] wdata;
  } req_t;

  state_t                 state, state_nxt;
  req_t                   req_q;
  logic [CW-1:0]          wcnt;
  logic [MEM_AW-1:0]      mem_addr_q;
  logic [31:0]            rdata_q, rsp_data_q, load_ext, wrep, merged;
  logic [NUM_LANES-1:0]   lane_sel;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic                   rsp_err_q, accept, addr_err, wait_done, is_load, is_sub_store;

  assign accept       = req_valid && (state == IDLE);
  assign is_load      = (req_q.op <= OP_LHU);
  assign is_sub_store = (req_q.op == OP_SB) || (req_q.op == OP_SH);
  assign wait_done    = (wcnt == CW'(RD_LATENCY - 1));

  // Any address bit above the memory window is an out-of-range access.
  always_comb begin
    addr_err = (req_addr >> (MEM_AW + 2)) != 32'd0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: if (req_addr[0])            addr_err = 1'b1;
      OP_LW, OP_SW:         if (req_addr[1:0] != 2'b00) addr_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = addr_err ? RESP : (req_op == OP_SW) ? WRITE : READ;
      READ:  state_nxt = WAIT;
      WAIT:  if (wait_done) state_nxt = is_sub_store ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:  req_ready = 1'b1;
      READ:  mem_re    = 1'b1;
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
      end
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (req_q.boff)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = req_q.boff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_q.op)
      OP_LB:   load_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_ext = {24'd0, ld_byte};
      OP_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_ext = {16'd0, ld_half};
      OP_LW:   load_ext = mem_rdata;
      default: load_ext = '0;
    endcase
  end

  // Store data is replicated across lanes; lane_sel picks which lanes take it.
  always_comb begin
    wrep     = req_q.wdata;
    lane_sel = '1;
    case (req_q.op)
      OP_SB: begin
        wrep     = {4{req_q.wdata[7:0]}};
        lane_sel = 4'b0001 << req_q.boff;
      end
      OP_SH: begin
        wrep     = {2{req_q.wdata[15:0]}};
        lane_sel = req_q.boff[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lsu_lane u_lane (
      .sel   (lane_sel[k]),
      .rbyte (rdata_q[8*k +: 8]),
      .wbyte (wrep[8*k +: 8]),
      .mbyte (merged[8*k +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      mem_addr_q <= '0;
      wcnt       <= '0;
      rdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        req_q      <= {req_op, req_addr[1:0], req_wdata};
        mem_addr_q <= req_addr[MEM_AW+1:2];
        rsp_err_q  <= addr_err;
        rsp_data_q <= '0;
      end
      wcnt <= (state == WAIT && !wait_done) ? wcnt + 1'b1 : '0;
      if (state == WAIT && wait_done) begin
        rdata_q <= mem_rdata;
        if (is_load) rsp_data_q <= load_ext;
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with RD_LATENCY=1, one with RD_LATENCY=3,
// each backed by its own behavioural memory; requests are steered to one instance at a time.

module tb_load_store_unit;
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
  } rsp_t;
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk, rst_n, req_valid, sel;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;

  logic        rdy1, re1, we1, rv1, rerr1, rdy3, re3, we3, rv3, rerr3;
  logic [9:0]  ma1, ma3;
  logic [31:0] wd1, rd1, rdat1, wd3, rd3, rdat3;

  logic        cur_ready, cur_re, cur_we, cur_rv, cur_err;
  logic [9:0]  cur_addr;
  logic [31:0] cur_wdata, cur_rdata;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  logic [31:0] em [2][1024];

  rsp_t rq[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   re_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  load_store_unit #(.MEM_AW(10), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy1),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(ma1), .mem_re(re1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd1),
    .rsp_valid(rv1), .rsp_data(rdat1), .rsp_err(rerr1)
  );

  load_store_unit #(.MEM_AW(10), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy3),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(ma3), .mem_re(re3), .mem_we(we3), .mem_wdata(wd3), .mem_rdata(rd3),
    .rsp_valid(rv3), .rsp_data(rdat3), .rsp_err(rerr3)
  );

  assign cur_ready = sel ? rdy3  : rdy1;
  assign cur_re    = sel ? re3   : re1;
  assign cur_we    = sel ? we3   : we1;
  assign cur_rv    = sel ? rv3   : rv1;
  assign cur_err   = sel ? rerr3 : rerr1;
  assign cur_addr  = sel ? ma3   : ma1;
  assign cur_wdata = sel ? wd3   : wd1;
  assign cur_rdata = sel ? rdat3 : rdat1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories; idle-cycle read data is a poison pattern.
  always @(posedge clk) begin
    if (we1) mem1[ma1] <= wd1;
    p1 <= re1 ? mem1[ma1] : 32'h5A5A5A5A;
  end
  assign rd1 = p1;

  always @(posedge clk) begin
    if (we3) mem3[ma3] <= wd3;
    p3[0] <= re3 ? mem3[ma3] : 32'h5A5A5A5A;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd3 = p3[2];

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (cur_re && cur_we) begin
        errors++;
        $display("FAIL re_we_overlap sel=%0d cyc=%0d", sel, cyc);
      end
      if (rq.size() > 0 && rq[0].acc <= cyc) begin
        checks++;
        if (cur_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_busy sel=%0d got=%b exp=0", sel, cur_ready);
        end
      end
      if (cur_re) re_cnt++;
      if (cur_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write sel=%0d addr=%h data=%h", sel, cur_addr, cur_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (cur_addr !== w.addr || cur_wdata !== w.data) begin
            errors++;
            $display("FAIL write sel=%0d got addr=%h data=%h exp addr=%h data=%h",
                     sel, cur_addr, cur_wdata, w.addr, w.data);
          end
        end
      end
      if (cur_rv) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp sel=%0d data=%h err=%b", sel, cur_rdata, cur_err);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          if (cur_rdata !== r.data || cur_err !== r.err || (cyc - r.acc + 1) != r.lat) begin
            errors++;
            $display("FAIL rsp sel=%0d got data=%h err=%b lat=%0d exp data=%h err=%b lat=%0d",
                     sel, cur_rdata, cur_err, cyc - r.acc + 1, r.data, r.err, r.lat);
          end
        end
      end
    end
  end

  // Drives one request, waits for acceptance and records the expected outcome.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    int lat_rd;
    rsp_t r;
    wr_t w;
    logic [31:0] word, nw;
    logic [7:0]  bt;
    logic [15:0] hf;
    logic        err;
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (cur_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout sel=%0d op=%0d addr=%h", sel, op, a);
      req_valid = 1'b0;
      return;
    end
    lat_rd = sel ? 3 : 1;
    word = em[sel][a[11:2]];
    bt = word[8*a[1:0] +: 8];
    hf = word[16*a[1] +: 16];
    err = (a[31:12] != 0) || ((op == 1 || op == 4 || op == 6) && a[0]) ||
          ((op == 2 || op == 7) && a[1:0] != 0);
    r.err = err; r.data = 32'd0; r.acc = cyc + 1; r.lat = 2 + lat_rd;
    nw = word;
    if (err) r.lat = 1;
    else begin
      case (op)
        3'd0: r.data = {{24{bt[7]}}, bt};
        3'd1: r.data = {{16{hf[15]}}, hf};
        3'd2: r.data = word;
        3'd3: r.data = {24'd0, bt};
        3'd4: r.data = {16'd0, hf};
        3'd5: begin nw[8*a[1:0] +: 8] = wd[7:0];  r.lat = 3 + lat_rd; end
        3'd6: begin nw[16*a[1] +: 16] = wd[15:0]; r.lat = 3 + lat_rd; end
        default: begin nw = wd; r.lat = 2; end
      endcase
      if (op >= 3'd5) begin
        w.addr = a[11:2]; w.data = nw;
        wq.push_back(w);
        em[sel][a[11:2]] = nw;
      end
    end
    rq.push_back(r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout sel=%0d rsp_left=%0d wr_left=%0d", sel, rq.size(), wq.size());
      rq.delete(); wq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; sel = 1'b0;
    req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy1, re1, we1, rv1, rerr1} !== 5'b10000 || {rdy3, re3, we3, rv3, rerr3} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b_%b exp=10000_10000",
               {rdy1, re1, we1, rv1, rerr1}, {rdy3, re3, we3, rv3, rerr3});
    end
    checks++;
    if ({ma1, wd1, rdat1} !== '0 || {ma3, wd3, rdat3} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h/%h wdata=%h/%h rdata=%h/%h exp all 0",
               ma1, ma3, wd1, wd3, rdat1, rdat3);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sw();
    issue(3'd7, 32'h10, 32'hDEADBEEF);
    drain();
  endtask

  task automatic test_loads();
    issue(3'd7, 32'h10, 32'h80FF7F01);
    issue(3'd0, 32'h13, 32'h0);
    issue(3'd3, 32'h13, 32'h0);
    issue(3'd1, 32'h12, 32'h0);
    issue(3'd4, 32'h10, 32'h0);
    issue(3'd0, 32'h11, 32'h0);
    issue(3'd1, 32'h10, 32'h0);
    issue(3'd2, 32'h10, 32'h0);
    drain();
  endtask

  task automatic test_sub_stores();
    issue(3'd7, 32'h10, 32'h11223344);
    issue(3'd5, 32'h11, 32'h123456AA);
    issue(3'd6, 32'h12, 32'h5555BEEF);
    issue(3'd2, 32'h10, 32'h0);
    issue(3'd5, 32'h10, 32'h000000C3);
    issue(3'd6, 32'h10, 32'hFFFF0102);
    issue(3'd2, 32'h10, 32'h0);
    drain();
  endtask

  task automatic test_errors();
    int re0 = re_cnt;
    issue(3'd2, 32'h02, 32'h0);
    issue(3'd6, 32'h01, 32'h1234);
    issue(3'd2, 32'h1000, 32'h0);
    issue(3'd4, 32'h03, 32'h0);
    issue(3'd7, 32'h11, 32'hFFFFFFFF);
    issue(3'd5, 32'h8000_0000, 32'hFF);
    drain();
    checks++;
    if (re_cnt != re0) begin
      errors++;
      $display("FAIL err_no_read got reads=%0d exp=0", re_cnt - re0);
    end
    issue(3'd7, 32'hFFC, 32'h0BADF00D);
    issue(3'd2, 32'hFFC, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) issue(3'd7, 32'(4 * i), $urandom);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = a | 32'h0001_0000;
      issue(3'($urandom_range(0, 7)), a, $urandom);
    end
    for (int i = 0; i < 8; i++) issue(3'd2, 32'(4 * i), 32'h0);
    drain();
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    logic [31:0] saved;
    issue(3'd7, 32'h20, 32'hCAFEF00D);
    drain();
    saved = em[sel][8];
    issue(3'd5, 32'h21, 32'h77);
    req_valid = 1'b0;
    while (!cur_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cur_we) begin
      errors++;
      $display("FAIL rmw_write_timeout sel=%0d", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cur_we !== 1'b0 || cur_re !== 1'b0 || cur_ready !== 1'b1 || cur_rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort sel=%0d got we=%b re=%b ready=%b rv=%b exp 0 0 1 0",
               sel, cur_we, cur_re, cur_ready, cur_rv);
    end
    rq.delete(); wq.delete();
    em[sel][8] = saved;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd2, 32'h20, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    sel = 1'b0;
    test_sw();
    test_loads();
    test_sub_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    sel = 1'b1;
    @(negedge clk);
    test_loads();
    test_sub_stores();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
